// File: rtl/memory_access_stage.sv
// memory_access_stage: load/store stage between execute and writeback.
// Drives the data-memory bus, stalls upstream while an access is in flight,
// and registers the writeback fields.
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses. When it is undefined, the offending low address bits are cleared.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ACCESS    | idle, or requesting the bus for the op held on the ex inputs
// WAIT_DATA | load granted, waiting for dmemRvalid
module memory_access_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exValid,
  input  logic [XLEN-1:0]       exPc,
  input  logic [XLEN-1:0]       exAluResult,
  input  logic [XLEN-1:0]       exStoreData,
  input  logic [1:0]            exMemOp,
  input  logic [1:0]            exMemSize,
  input  logic                  exLoadUnsigned,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exRegWrite,
  output logic                  memStall,
  output logic                  dmemReq,
  output logic                  dmemWe,
  output logic [XLEN-1:0]       dmemAddr,
  output logic [XLEN-1:0]       dmemWdata,
  output logic [3:0]            dmemWstrb,
  input  logic                  dmemGnt,
  input  logic                  dmemRvalid,
  input  logic [XLEN-1:0]       dmemRdata,
  output logic                  wbValid,
  output logic [XLEN-1:0]       wbPc,
  output logic [REG_ADDR_W-1:0] wbRd,
  output logic                  wbRegWrite,
  output logic [XLEN-1:0]       wbData,
  output logic                  wbMisalign,
  output logic [XLEN-1:0]       wbBadAddr
);

  typedef enum logic {ACCESS, WAIT_DATA} state_t;

  state_t                state_q, state_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]       wb_pc_q, wb_pc_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  wb_misalign_q, wb_misalign_d;
  logic [XLEN-1:0]       wb_bad_addr_q, wb_bad_addr_d;

  logic            is_load, is_store, is_mem, is_half, is_word;
  logic            misaligned, trap;
  logic [1:0]      lo;
  logic            complete;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  // Decode the op, resolve the effective lane offset and extract load data.
  always_comb begin
    is_load    = exValid && (exMemOp == 2'd1);
    is_store   = exValid && (exMemOp == 2'd2);
    is_mem     = is_load || is_store;
    is_half    = (exMemSize == 2'd1);
    is_word    = (exMemSize[1] == 1'b1);
    misaligned = (is_half && exAluResult[0]) || (is_word && (exAluResult[1:0] != 2'b00));
`ifdef MEM_MISALIGN_TRAP_EN
    trap = is_mem && misaligned;
    lo   = exAluResult[1:0];
`else
    trap = 1'b0;
    lo   = is_word ? 2'b00 : (is_half ? {exAluResult[1], 1'b0} : exAluResult[1:0]);
`endif
    ld_byte = dmemRdata[{lo, 3'b000} +: 8];
    ld_half = lo[1] ? dmemRdata[31:16] : dmemRdata[15:0];
    if (is_word)
      ld_data = dmemRdata;
    else if (is_half)
      ld_data = {{16{ld_half[15] & ~exLoadUnsigned}}, ld_half};
    else
      ld_data = {{24{ld_byte[7] & ~exLoadUnsigned}}, ld_byte};
  end

  // Next state, bus outputs, stall and writeback next values.
  always_comb begin
    state_d   = state_q;
    dmemReq   = 1'b0;
    dmemWe    = 1'b0;
    dmemAddr  = '0;
    dmemWdata = '0;
    dmemWstrb = 4'b0000;
    complete  = 1'b0;

    case (state_q)
      ACCESS: begin
        if (trap) begin
          complete = 1'b1;
        end else if (is_mem) begin
          dmemReq  = 1'b1;
          dmemWe   = is_store;
          dmemAddr = {exAluResult[XLEN-1:2], 2'b00};
          if (is_store) begin
            if (is_word) begin
              dmemWdata = exStoreData;
              dmemWstrb = 4'b1111;
            end else if (is_half) begin
              dmemWdata = {2{exStoreData[15:0]}};
              dmemWstrb = lo[1] ? 4'b1100 : 4'b0011;
            end else begin
              dmemWdata = {4{exStoreData[7:0]}};
              dmemWstrb = 4'b0001 << lo;
            end
          end
          if (dmemGnt) begin
            if (is_store) complete = 1'b1;
            else          state_d  = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (dmemRvalid) begin
          complete = 1'b1;
          state_d  = ACCESS;
        end
      end
      default: state_d = ACCESS;
    endcase

    memStall = is_mem && !complete;

    wb_valid_d     = 1'b0;
    wb_pc_d        = wb_pc_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_data_d      = wb_data_q;
    wb_misalign_d  = wb_misalign_q;
    wb_bad_addr_d  = wb_bad_addr_q;
    if (!memStall) begin
      wb_valid_d     = exValid;
      wb_pc_d        = exPc;
      wb_rd_d        = exRd;
      wb_reg_write_d = exRegWrite && !is_store && !trap;
      wb_data_d      = (is_load && !trap) ? ld_data : exAluResult;
      wb_misalign_d  = trap;
      wb_bad_addr_d  = trap ? exAluResult : '0;
    end
  end

  // State and writeback register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ACCESS;
      wb_valid_q     <= 1'b0;
      wb_pc_q        <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      wb_misalign_q  <= 1'b0;
      wb_bad_addr_q  <= '0;
    end else begin
      state_q        <= state_d;
      wb_valid_q     <= wb_valid_d;
      wb_pc_q        <= wb_pc_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      wb_misalign_q  <= wb_misalign_d;
      wb_bad_addr_q  <= wb_bad_addr_d;
    end
  end

  assign wbValid    = wb_valid_q;
  assign wbPc       = wb_pc_q;
  assign wbRd       = wb_rd_q;
  assign wbRegWrite = wb_reg_write_q;
  assign wbData     = wb_data_q;
  assign wbMisalign = wb_misalign_q;
  assign wbBadAddr  = wb_bad_addr_q;

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes the execute stage's next-stage pipe register and performs loads and stores on the data-memory bus.
- Drives the writeback pipe register and raises a stall to the controller while a memory access is outstanding.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- exValid  in  1  execute stage holds a valid instruction
- exPc  in  XLEN  instruction PC
- exAluResult  in  XLEN  ALU result; this is the effective address for memory ops
- exStoreData  in  XLEN  rs2 value for stores
- exMemOp  in  2  0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE)
- exMemSize  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- exLoadUnsigned  in  1  zero-extend the load when 1
- exRd  in  REG_ADDR_W  destination register
- exRegWrite  in  1  instruction writes rd
- memStall  out  1  freeze upstream stages (to controller)
- dmemReq  out  1  bus request
- dmemWe  out  1  1=write
- dmemAddr  out  XLEN  word-aligned address (low two bits always 0)
- dmemWdata  out  XLEN  lane-replicated store data
- dmemWstrb  out  4  byte enables
- dmemGnt  in  1  request accepted this cycle
- dmemRvalid  in  1  read data valid
- dmemRdata  in  XLEN  read data
- wbValid  out  1  writeback register valid
- wbPc  out  XLEN  PC
- wbRd  out  REG_ADDR_W  destination register
- wbRegWrite  out  1  write enable
- wbData  out  XLEN  result
- wbMisalign  out  1  misaligned-access flag
- wbBadAddr  out  XLEN  faulting address

Behaviour:
- Reset:
  - FSM goes to ACCESS.
  - All wb* outputs are 0.
  - memStall, dmemReq, dmemWe, dmemAddr, dmemWdata and dmemWstrb are 0 whenever FSM=ACCESS and no memory op is present.
  - A reset asserted mid-access abandons the access; any later dmemRvalid is ignored until a new load is granted.
- Upstream contract: inputs are held stable while memStall=1.
- isMem = exValid & (exMemOp is LOAD or STORE).
- FSM states:
  - ACCESS:
    - If isMem, drive dmemReq=1, dmemWe=(STORE), address and data combinationally.
    - STORE with dmemGnt: completes this cycle.
    - LOAD with dmemGnt: go to WAIT_DATA.
    - No dmemGnt: stay in ACCESS and keep requesting.
  - WAIT_DATA:
    - dmemReq=0.
    - On dmemRvalid the load completes and the FSM returns to ACCESS.
    - dmemRvalid is never earlier than the cycle after grant. dmemRvalid seen in ACCESS is ignored.
- complete = (ACCESS & STORE & dmemGnt) | (WAIT_DATA & dmemRvalid).
- memStall = isMem & ~complete (combinational).
- Writeback register update (every cycle):
  - memStall=0: wbValid<=exValid and the remaining fields are loaded.
  - memStall=1: wbValid<=0 (bubble); other fields don't-care but held.
- wbData source:
  - NONE: exAluResult.
  - LOAD: extracted data.
  - STORE: exAluResult, and wbRegWrite forced 0.
- Load extraction:
  - Byte: lane addr[1:0], sign- or zero-extended.
  - Half: lane addr[1], sign- or zero-extended.
  - Word: whole dmemRdata.
- Store encoding:
  - Byte: dmemWdata = {4{sd[7:0]}}, wstrb = 0001<<addr[1:0].
  - Half: dmemWdata = {2{sd[15:0]}}, wstrb = 0011<<(2*addr[1]).
  - Word: dmemWdata = sd, wstrb = 1111.
- Latency:
  - Non-memory op: 1 cycle.
  - Store: grant cycle + 1.
  - Load: rvalid cycle + 1.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus request and completes in ACCESS the same cycle.
  - Next cycle: wbValid=1, wbRegWrite=0, wbMisalign=1, wbBadAddr=exAluResult.
- MEM_MISALIGN_TRAP_EN undefined:
  - Offending low address bits are forced to 0 before lane/strobe selection.
  - wbMisalign and wbBadAddr are tied to 0.

Test Plan:
- ALU op: rd=5, result 0x1234, no memory op -> next cycle wbValid=1, wbData=0x1234, memStall=0, dmemReq never asserted.
- Signed byte load at 0x1003: dmemGnt immediate, dmemRdata=0x80FFFFFF two cycles later -> memStall high for 2 cycles; then wbData=0xFFFFFF80, wbRegWrite=1.
- Half store of 0xBEEF at 0x2002: dmemGnt withheld for 3 cycles -> dmemReq held 4 cycles, dmemWstrb=1100, dmemWdata=0xBEEFBEEF; wbRegWrite=0 one cycle after grant.
- Unsigned half load at 0x2002 with rdata 0x8001xxxx -> wbData=0x00008001; back-to-back with an ALU op -> exactly one bubble (wbValid=0) per stall cycle.
- Reset asserted in WAIT_DATA: rst pulse, then a stray dmemRvalid -> FSM in ACCESS, all wb* outputs 0, no writeback produced.
- With MEM_MISALIGN_TRAP_EN: word load at 0x3001 -> no dmemReq; next cycle wbMisalign=1, wbBadAddr=0x3001, wbRegWrite=0.
